regfile_writeback_arbiter: RTL
==============================

// Module: regfile_writeback_arbiter
// PURPOSE
//  Write-side initiator for the MIPS register file. Merges single-cycle ALU results with
//  long-latency results (load/mul/div) into the file's one write port (wr/controle/entrada).
//  ALU results have absolute priority. Long results queue in a small FIFO and drain in free cycles.
//  Sits between the EX/MEM result buses and registerfile; the hazard unit observes pending/count.
// PARAMETERS
//  DATA_W   32  register data width
//  ADDR_W   5   register index width
//  DEPTH    4   long-result FIFO entries, power of 2, >=2
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        synchronous, active-high
//  alu_valid  in   1        ALU result present this cycle; always accepted, no backpressure
//  alu_rd     in   ADDR_W   ALU destination register
//  alu_data   in   DATA_W   ALU result
//  lng_valid  in   1        long-latency result offered
//  lng_ready  out  1        FIFO can accept; transfer = lng_valid & lng_ready at rising edge
//  lng_rd     in   ADDR_W   long-result destination
//  lng_data   in   DATA_W   long result
//  wr         out  1        register-file write enable, registered
//  controle   out  ADDR_W   register-file write address, registered
//  entrada    out  DATA_W   register-file write data, registered
//  pending    out  1        FIFO non-empty (count != 0)
//  count      out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  - Reset (sync, active-high): FIFO flushed, count=0, wr=0, controle=0, entrada=0.
//    lng_ready=0 while reset is high. Reset mid-drain discards all queued entries; no write follows.
//  - lng_ready = !reset && count<DEPTH, from registered state only (no path from any valid input).
//    A full FIFO refuses a push even if it pops in the same cycle.
//  - Selection at each edge:
//    - alu_valid && alu_rd!=0: output regs load {1,alu_rd,alu_data}.
//    - else if FIFO non-empty: pop head; output regs load {1,head.rd,head.data}.
//    - else: wr<=0; controle/entrada hold their last values.
//  - Latency:
//    - ALU: 1 cycle; wr is high in the cycle after the sampling edge, for exactly one cycle per result.
//    - Long: earliest 2 cycles. A push at edge k can pop no earlier than edge k+1.
//  - Register 0:
//    - alu_valid with alu_rd=0 drops the write, and the FIFO may drain in that slot.
//    - A long result with lng_rd=0 is accepted (handshake completes) and discarded, not pushed.
//  - Ordering:
//    - FIFO is strictly in order.
//    - ALU writes can overtake queued long writes. WAW between the two paths is prevented upstream by the hazard unit using pending.
//  - Simultaneous push+pop on a non-full FIFO: count unchanged, both take effect.
//  - Starvation: continuous ALU traffic stalls draining indefinitely. This is by design; lng_ready backpressures.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    - Adds ports byp_rs (in ADDR_W), byp_hit (out 1) and byp_data (out DATA_W), all combinational.
//    - The newest queued FIFO entry with rd==byp_rs wins.
//    - If no FIFO entry matches, the output register matches when wr && controle==byp_rs.
//    - byp_rs=0 always gives byp_hit=0. byp_data=0 when there is no hit.
//  WB_BYPASS_EN undefined: the three ports and all search logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Shared header mips_defs.vh:
//    - DATA_W and ADDR_W defaults.
//    - REG_ZERO constant.
//    - Width of the packed {rd,data} entry.
//  - Sub-module wb_fifo: synchronous FIFO of DEPTH x (ADDR_W+DATA_W).
//    - Ports: push, pop, full, empty, count, head, plus entry-array visibility for the bypass search.
//  - Top level holds the selection mux, the output registers, the handshake and the optional bypass.
// TESTING
//  1 Reset 2 cycles -> wr=0, controle=0, entrada=0, count=0, lng_ready=0; after release lng_ready=1.
//  2 alu_valid rd=5 data=275 for one edge -> next cycle wr=1 controle=5 entrada=275; following cycle wr=0.
//  3 Same edge: lng rd=3 data=300 + alu rd=4 data=325
//    -> cycle+1: r4=325; cycle+2: r3=300; pending 1 then 0.
//  4 alu_valid held high (rd=1..), 5 long offers -> 4 accepted, lng_ready=0, count=4.
//    Drop alu_valid -> 4 writes in push order, count 4->0.
//  5 alu rd=0 with FIFO holding r6=50 -> r6=50 written in that slot. Long rd=0 accepted -> count unchanged, no wr.
//    Reset with count=3 -> count=0, no wr after.
//  6 WB_BYPASS_EN, hold alu_valid so the FIFO keeps r7=100 then r7=200:
//    -> byp_rs=7: byp_hit=1, byp_data=200.
//    -> byp_rs=0: byp_hit=0.
//    Build without macro compiles with the ports absent.

Source files
------------

// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared register-file definitions for the writeback arbiter: default widths,
// the hard-wired zero register index and the width of a queued {rd,data} entry.
package regfile_writeback_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
// wb_fifo: synchronous DEPTH-entry queue of packed {rd,data} long results.
// With WB_BYPASS_EN defined the storage array and read pointer are exported for the bypass search.
module wb_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 37
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ENTRY_W-1:0]             push_entry,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [ENTRY_W-1:0]             head
`ifdef WB_BYPASS_EN
  ,
  output logic [DEPTH-1:0][ENTRY_W-1:0]  entries,
  output logic [$clog2(DEPTH)-1:0]       rd_ptr
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][ENTRY_W-1:0] r_mem;
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [CNT_W-1:0]              r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

`ifdef WB_BYPASS_EN
  assign entries = r_mem;
  assign rd_ptr  = r_rd_ptr;
`endif

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write port arbiter: ALU results win every slot, long results queue and drain in free slots.
// Optional WB_BYPASS_EN adds a combinational forwarding search (byp_rs/byp_hit/byp_data).
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [ADDR_W-1:0]             alu_rd,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          lng_valid,
  output logic                          lng_ready,
  input  logic [ADDR_W-1:0]             lng_rd,
  input  logic [DATA_W-1:0]             lng_data,
  output logic                          wr,
  output logic [ADDR_W-1:0]             controle,
  output logic [DATA_W-1:0]             entrada,
  output logic                          pending,
  output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]             byp_rs,
  output logic                          byp_hit,
  output logic [DATA_W-1:0]             byp_data
`endif
);

  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = $clog2(DEPTH);

  logic               w_alu_take;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;

  logic               r_wr;
  logic [ADDR_W-1:0]  r_controle;
  logic [DATA_W-1:0]  r_entrada;

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0][ENTRY_W-1:0] w_entries;
  logic [PTR_W-1:0]              w_rd_ptr;
`endif

  assign w_alu_take = alu_valid && (alu_rd != ADDR_W'(REG_ZERO));
  assign w_pop      = !w_alu_take && !w_empty;
  // A zero-destination long result completes the handshake but never enters the queue.
  assign lng_ready  = !reset && !w_full;
  assign w_push     = lng_valid && lng_ready && (lng_rd != ADDR_W'(REG_ZERO));

  wb_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_wb_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (w_push),
    .pop        (w_pop),
    .push_entry ({lng_rd, lng_data}),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count),
    .head       (w_head)
`ifdef WB_BYPASS_EN
    ,
    .entries    (w_entries),
    .rd_ptr     (w_rd_ptr)
`endif
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr       <= 1'b0;
      r_controle <= '0;
      r_entrada  <= '0;
    end else if (w_alu_take) begin
      r_wr       <= 1'b1;
      r_controle <= alu_rd;
      r_entrada  <= alu_data;
    end else if (w_pop) begin
      r_wr       <= 1'b1;
      r_controle <= w_head[ENTRY_W-1 -: ADDR_W];
      r_entrada  <= w_head[DATA_W-1:0];
    end else begin
      r_wr <= 1'b0;
    end
  end

  assign wr       = r_wr;
  assign controle = r_controle;
  assign entrada  = r_entrada;
  assign pending  = (w_count != '0);
  assign count    = w_count;

`ifdef WB_BYPASS_EN
  logic               w_fifo_hit;
  logic [DATA_W-1:0]  w_fifo_data;
  logic [PTR_W-1:0]   w_idx;

  // Walk oldest to newest so the newest matching entry is the one left standing.
  always_comb begin
    w_fifo_hit  = 1'b0;
    w_fifo_data = '0;
    w_idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = w_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < w_count) && (w_entries[w_idx][ENTRY_W-1 -: ADDR_W] == byp_rs)) begin
        w_fifo_hit  = 1'b1;
        w_fifo_data = w_entries[w_idx][DATA_W-1:0];
      end
    end
  end

  assign byp_hit  = (byp_rs != ADDR_W'(REG_ZERO)) &&
                    (w_fifo_hit || (r_wr && (r_controle == byp_rs)));
  assign byp_data = !byp_hit   ? '0 :
                    w_fifo_hit ? w_fifo_data : r_entrada;
`endif

endmodule
